// File: rtl/timing_gen.sv
// Two-phase clock enable and machine-cycle phase generator for the MCS-4 core.
// Provides hold/acknowledge, slave re-alignment to an external SYNC and a TEST synchroniser.
module timing_gen #(
  parameter int CLK_DIV     = 2,
  parameter int NUM_PHASES  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic                  sysclk,
  input  logic                  poc,
  input  logic                  hold_req,
  output logic                  hold_ack,
  input  logic                  slave_mode,
  input  logic                  ext_sync,
  input  logic                  test_pad,
  output logic                  test_n,
  output logic                  clk1,
  output logic                  clk2,
  output logic [NUM_PHASES-1:0] phase,
  output logic                  sync,
  output logic                  resync_err,
  output logic [CNT_W-1:0]      cyc_cnt
);

  localparam int Q_W = $clog2(4 * CLK_DIV);

  localparam logic [Q_W-1:0] Q_ZERO   = Q_W'(0);
  localparam logic [Q_W-1:0] Q_ONE    = Q_W'(1);
  localparam logic [Q_W-1:0] Q_LAST   = Q_W'(4 * CLK_DIV - 1);
  localparam logic [Q_W-1:0] Q_ADV    = Q_W'(3 * CLK_DIV - 1);
  localparam logic [Q_W-1:0] Q_C1_END = Q_W'(CLK_DIV);
  localparam logic [Q_W-1:0] Q_C2_LO  = Q_W'(2 * CLK_DIV);
  localparam logic [Q_W-1:0] Q_C2_HI  = Q_W'(3 * CLK_DIV);

  localparam logic [NUM_PHASES-1:0] PH_FIRST = NUM_PHASES'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t                  state_r, state_s;
  logic [Q_W-1:0]          q_r, q_s;
  logic [NUM_PHASES-1:0]   phase_r, phase_s;
  logic [CNT_W-1:0]        cnt_r, cnt_s;
  logic                    clk1_r, clk1_s;
  logic                    clk2_r, clk2_s;
  logic                    hold_ack_r, hold_ack_s;
  logic                    resync_err_r, resync_err_s;
  logic [SYNC_STAGES-1:0]  test_sync_r;
  logic                    boundary_s;

  assign boundary_s = (q_r == Q_LAST) && phase_r[0];

  // Next-state, ring advance, hold handshake and clock-enable decode
  always_comb begin
    state_s      = state_r;
    q_s          = q_r;
    phase_s      = phase_r;
    cnt_s        = cnt_r;
    hold_ack_s   = 1'b0;
    resync_err_s = 1'b0;

    case (state_r)
      ST_IDLE: begin
        state_s = ST_RUN;
        q_s     = Q_ZERO;
      end

      ST_RUN: begin
        if (boundary_s && hold_req) begin
          state_s    = ST_HOLD;
          q_s        = Q_ZERO;
          hold_ack_s = 1'b1;
        end else begin
          if (q_r == Q_LAST) begin
            q_s = Q_ZERO;
          end else begin
            q_s = q_r + Q_ONE;
          end

          // Advance happens as clk2 falls; slave mode may snap to A1 or stall at the last slot
          if (q_r == Q_ADV) begin
            if (slave_mode && ext_sync) begin
              phase_s      = PH_FIRST;
              cnt_s        = cnt_r + CNT_W'(1);
              resync_err_s = ~phase_r[NUM_PHASES-1];
            end else if (slave_mode && phase_r[NUM_PHASES-1]) begin
              phase_s = phase_r;
            end else begin
              phase_s = {phase_r[NUM_PHASES-2:0], phase_r[NUM_PHASES-1]};
              if (phase_r[NUM_PHASES-1]) begin
                cnt_s = cnt_r + CNT_W'(1);
              end else begin
                cnt_s = cnt_r;
              end
            end
          end else begin
            phase_s = phase_r;
          end
        end
      end

      ST_HOLD: begin
        if (hold_req) begin
          hold_ack_s = 1'b1;
        end else begin
          state_s = ST_RUN;
        end
      end

      default: begin
        state_s = ST_IDLE;
        q_s     = Q_ZERO;
        phase_s = PH_FIRST;
      end
    endcase

    clk1_s = (state_s == ST_RUN) && (q_s < Q_C1_END);
    clk2_s = (state_s == ST_RUN) && (q_s >= Q_C2_LO) && (q_s < Q_C2_HI);
  end

  // State register; every output is a flop so poc clears them without waiting for an edge
  always_ff @(posedge sysclk or posedge poc) begin
    if (poc) begin
      state_r      <= ST_IDLE;
      q_r          <= Q_ZERO;
      phase_r      <= PH_FIRST;
      cnt_r        <= '0;
      clk1_r       <= 1'b0;
      clk2_r       <= 1'b0;
      hold_ack_r   <= 1'b0;
      resync_err_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      q_r          <= q_s;
      phase_r      <= phase_s;
      cnt_r        <= cnt_s;
      clk1_r       <= clk1_s;
      clk2_r       <= clk2_s;
      hold_ack_r   <= hold_ack_s;
      resync_err_r <= resync_err_s;
    end
  end

  // TEST pin synchroniser chain
  always_ff @(posedge sysclk or posedge poc) begin
    if (poc) begin
      test_sync_r <= '0;
    end else begin
      test_sync_r <= {test_sync_r[SYNC_STAGES-2:0], test_pad};
    end
  end

  assign clk1       = clk1_r;
  assign clk2       = clk2_r;
  assign phase      = phase_r;
  assign sync       = phase_r[NUM_PHASES-1];
  assign cyc_cnt    = cnt_r;
  assign hold_ack   = hold_ack_r;
  assign resync_err = resync_err_r;
  assign test_n     = ~test_sync_r[SYNC_STAGES-1];

endmodule

// File: tb/tb_timing_gen.sv
// Directed self-checking bench for timing_gen: defaults instance plus a D=1, N=4, CNT_W=2 instance.
module tb_timing_gen;

  logic       sysclk;
  logic       poc;
  logic       hold_req;
  logic       slave_mode;
  logic       ext_sync;
  logic       test_pad;

  logic       hold_ack, test_n, clk1, clk2, sync, resync_err;
  logic [7:0] phase;
  logic [15:0] cyc_cnt;

  logic       hold_ack2, test_n2, clk1_2, clk2_2, sync2, resync_err2;
  logic [3:0] phase2;
  logic [1:0] cyc_cnt2;

  int errors = 0;
  int checks = 0;

  timing_gen dut (
    .sysclk(sysclk), .poc(poc), .hold_req(hold_req), .hold_ack(hold_ack),
    .slave_mode(slave_mode), .ext_sync(ext_sync), .test_pad(test_pad), .test_n(test_n),
    .clk1(clk1), .clk2(clk2), .phase(phase), .sync(sync),
    .resync_err(resync_err), .cyc_cnt(cyc_cnt)
  );

  timing_gen #(.CLK_DIV(1), .NUM_PHASES(4), .SYNC_STAGES(2), .CNT_W(2)) dut2 (
    .sysclk(sysclk), .poc(poc), .hold_req(hold_req), .hold_ack(hold_ack2),
    .slave_mode(slave_mode), .ext_sync(ext_sync), .test_pad(test_pad), .test_n(test_n2),
    .clk1(clk1_2), .clk2(clk2_2), .phase(phase2), .sync(sync2),
    .resync_err(resync_err2), .cyc_cnt(cyc_cnt2)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  // Hold poc for two cycles and release it at a falling edge; the next rising edge is edge 1.
  task automatic apply_reset();
    poc = 1'b1;
    hold_req = 1'b0;
    slave_mode = 1'b0;
    ext_sync = 1'b0;
    repeat (2) @(negedge sysclk);
    poc = 1'b0;
  endtask

  task automatic test_reset();
    poc = 1'b1;
    @(negedge sysclk);
    checks++; if (clk1 !== 1'b0) begin errors++; $display("FAIL reset_clk1 got=%b exp=0", clk1); end
    checks++; if (clk2 !== 1'b0) begin errors++; $display("FAIL reset_clk2 got=%b exp=0", clk2); end
    checks++; if (hold_ack !== 1'b0) begin errors++; $display("FAIL reset_hold_ack got=%b exp=0", hold_ack); end
    checks++; if (resync_err !== 1'b0) begin errors++; $display("FAIL reset_resync_err got=%b exp=0", resync_err); end
    checks++; if (phase !== 8'h01) begin errors++; $display("FAIL reset_phase got=%h exp=01", phase); end
    checks++; if (sync !== 1'b0) begin errors++; $display("FAIL reset_sync got=%b exp=0", sync); end
    checks++; if (cyc_cnt !== 16'd0) begin errors++; $display("FAIL reset_cyc_cnt got=%0d exp=0", cyc_cnt); end
    checks++; if (test_n !== 1'b1) begin errors++; $display("FAIL reset_test_n got=%b exp=1", test_n); end
    checks++; if (phase2 !== 4'h1) begin errors++; $display("FAIL reset_phase2 got=%h exp=1", phase2); end
  endtask

  task automatic test_reset_release();
    int idx;
    logic e_c1, e_c2;
    logic [7:0] e_ph;
    logic [15:0] e_cnt;
    apply_reset();
    for (int k = 1; k <= 64; k++) begin
      @(negedge sysclk);
      e_c1 = ((k - 1) % 8) < 2;
      e_c2 = (((k - 1) % 8) >= 4) && (((k - 1) % 8) < 6);
      idx = (k < 7) ? 0 : (((k - 7) / 8 + 1) % 8);
      e_ph = 8'(1) << idx;
      e_cnt = (k >= 63) ? 16'd1 : 16'd0;
      checks++; if (clk1 !== e_c1) begin errors++; $display("FAIL run_clk1 cyc=%0d got=%b exp=%b", k, clk1, e_c1); end
      checks++; if (clk2 !== e_c2) begin errors++; $display("FAIL run_clk2 cyc=%0d got=%b exp=%b", k, clk2, e_c2); end
      checks++; if ((clk1 & clk2) !== 1'b0) begin errors++; $display("FAIL run_overlap cyc=%0d got=1 exp=0", k); end
      checks++; if (phase !== e_ph) begin errors++; $display("FAIL run_phase cyc=%0d got=%h exp=%h", k, phase, e_ph); end
      checks++; if (sync !== (idx == 7)) begin errors++; $display("FAIL run_sync cyc=%0d got=%b exp=%b", k, sync, (idx == 7)); end
      checks++; if (cyc_cnt !== e_cnt) begin errors++; $display("FAIL run_cyc_cnt cyc=%0d got=%0d exp=%0d", k, cyc_cnt, e_cnt); end
    end
  endtask

  task automatic test_hold();
    apply_reset();
    for (int k = 1; k <= 64; k++) begin
      @(negedge sysclk);
      if (k == 19) hold_req = 1'b1;
      checks++; if (hold_ack !== 1'b0) begin errors++; $display("FAIL hold_early_ack cyc=%0d got=%b exp=0", k, hold_ack); end
    end
    @(negedge sysclk);
    checks++; if (hold_ack !== 1'b1) begin errors++; $display("FAIL hold_ack_rise got=%b exp=1", hold_ack); end
    checks++; if (clk1 !== 1'b0) begin errors++; $display("FAIL hold_clk1_low got=%b exp=0", clk1); end
    checks++; if (cyc_cnt !== 16'd1) begin errors++; $display("FAIL hold_cyc_cnt got=%0d exp=1", cyc_cnt); end
    for (int k = 0; k < 10; k++) begin
      @(negedge sysclk);
      checks++; if ({hold_ack, clk1, clk2} !== 3'b100) begin errors++; $display("FAIL hold_frozen_ctl got=%b exp=100", {hold_ack, clk1, clk2}); end
      checks++; if ((phase !== 8'h01) || (cyc_cnt !== 16'd1)) begin errors++; $display("FAIL hold_frozen_ring got=%h/%0d exp=01/1", phase, cyc_cnt); end
    end
    hold_req = 1'b0;
    @(negedge sysclk);
    checks++; if (clk1 !== 1'b1) begin errors++; $display("FAIL unhold_clk1 got=%b exp=1", clk1); end
    checks++; if (hold_ack !== 1'b0) begin errors++; $display("FAIL unhold_ack got=%b exp=0", hold_ack); end
    @(negedge sysclk);
    checks++; if (clk1 !== 1'b1) begin errors++; $display("FAIL unhold_clk1_2nd got=%b exp=1", clk1); end
    @(negedge sysclk);
    checks++; if (clk1 !== 1'b0) begin errors++; $display("FAIL unhold_clk1_end got=%b exp=0", clk1); end
    repeat (3) @(negedge sysclk);
    checks++; if (phase !== 8'h01) begin errors++; $display("FAIL unhold_phase_pre got=%h exp=01", phase); end
    @(negedge sysclk);
    checks++; if (phase !== 8'h02) begin errors++; $display("FAIL unhold_phase_adv got=%h exp=02", phase); end
  endtask

  task automatic test_slave_resync();
    apply_reset();
    slave_mode = 1'b1;
    repeat (30) @(negedge sysclk);
    checks++; if (phase !== 8'h08) begin errors++; $display("FAIL resync_pre_phase got=%h exp=08", phase); end
    ext_sync = 1'b1;
    @(negedge sysclk);
    ext_sync = 1'b0;
    checks++; if (phase !== 8'h01) begin errors++; $display("FAIL resync_phase got=%h exp=01", phase); end
    checks++; if (resync_err !== 1'b1) begin errors++; $display("FAIL resync_err_pulse got=%b exp=1", resync_err); end
    checks++; if (cyc_cnt !== 16'd1) begin errors++; $display("FAIL resync_cyc_cnt got=%0d exp=1", cyc_cnt); end
    @(negedge sysclk);
    checks++; if (resync_err !== 1'b0) begin errors++; $display("FAIL resync_err_width got=%b exp=0", resync_err); end
    repeat (7) @(negedge sysclk);
    checks++; if (phase !== 8'h02) begin errors++; $display("FAIL resync_next_phase got=%h exp=02", phase); end
    slave_mode = 1'b0;
  endtask

  task automatic test_slave_wait();
    apply_reset();
    slave_mode = 1'b1;
    repeat (55) @(negedge sysclk);
    checks++; if (phase !== 8'h80) begin errors++; $display("FAIL wait_enter_phase got=%h exp=80", phase); end
    for (int k = 56; k <= 102; k++) begin
      @(negedge sysclk);
      checks++;
      if ((sync !== 1'b1) || (phase !== 8'h80) || (cyc_cnt !== 16'd0) || (resync_err !== 1'b0)) begin
        errors++;
        $display("FAIL wait_stuck cyc=%0d got=sync%b ph%h cnt%0d err%b exp=sync1 ph80 cnt0 err0", k, sync, phase, cyc_cnt, resync_err);
      end
    end
    ext_sync = 1'b1;
    @(negedge sysclk);
    ext_sync = 1'b0;
    checks++; if (phase !== 8'h01) begin errors++; $display("FAIL wait_release_phase got=%h exp=01", phase); end
    checks++; if (resync_err !== 1'b0) begin errors++; $display("FAIL wait_release_err got=%b exp=0", resync_err); end
    checks++; if (cyc_cnt !== 16'd1) begin errors++; $display("FAIL wait_release_cnt got=%0d exp=1", cyc_cnt); end
    slave_mode = 1'b0;
  endtask

  task automatic test_test_pad();
    test_pad = 1'b1;
    @(negedge sysclk);
    checks++; if (test_n !== 1'b1) begin errors++; $display("FAIL test_rise_1edge got=%b exp=1", test_n); end
    @(negedge sysclk);
    checks++; if (test_n !== 1'b0) begin errors++; $display("FAIL test_rise_2edge got=%b exp=0", test_n); end
    checks++; if (test_n2 !== 1'b0) begin errors++; $display("FAIL test2_rise got=%b exp=0", test_n2); end
    test_pad = 1'b0;
    @(negedge sysclk);
    checks++; if (test_n !== 1'b0) begin errors++; $display("FAIL test_fall_1edge got=%b exp=0", test_n); end
    @(negedge sysclk);
    checks++; if (test_n !== 1'b1) begin errors++; $display("FAIL test_fall_2edge got=%b exp=1", test_n); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    test_pad = 1'b1;
    repeat (109) @(negedge sysclk);
    checks++; if ({clk2, phase} !== {1'b1, 8'h20}) begin errors++; $display("FAIL mid_pre got=%b/%h exp=1/20", clk2, phase); end
    checks++; if ((cyc_cnt !== 16'd1) || (test_n !== 1'b0)) begin errors++; $display("FAIL mid_pre_cnt got=%0d/%b exp=1/0", cyc_cnt, test_n); end
    #2 poc = 1'b1;
    #1;
    checks++; if ({clk1, clk2, sync} !== 3'b000) begin errors++; $display("FAIL mid_async_clk got=%b exp=000", {clk1, clk2, sync}); end
    checks++; if (phase !== 8'h01) begin errors++; $display("FAIL mid_async_phase got=%h exp=01", phase); end
    checks++; if (cyc_cnt !== 16'd0) begin errors++; $display("FAIL mid_async_cnt got=%0d exp=0", cyc_cnt); end
    checks++; if ({test_n, hold_ack, resync_err} !== 3'b100) begin errors++; $display("FAIL mid_async_misc got=%b exp=100", {test_n, hold_ack, resync_err}); end
    test_pad = 1'b0;
  endtask

  task automatic test_param_sweep();
    int idx;
    logic [3:0] e_ph;
    logic [1:0] e_cnt;
    apply_reset();
    for (int k = 1; k <= 68; k++) begin
      @(negedge sysclk);
      idx = (k < 4) ? 0 : (((k - 4) / 4 + 1) % 4);
      e_ph = 4'(1) << idx;
      e_cnt = 2'((k / 16) % 4);
      checks++; if (clk1_2 !== (((k - 1) % 4) == 0)) begin errors++; $display("FAIL p_clk1 cyc=%0d got=%b", k, clk1_2); end
      checks++; if (clk2_2 !== (((k - 1) % 4) == 2)) begin errors++; $display("FAIL p_clk2 cyc=%0d got=%b", k, clk2_2); end
      checks++; if ({sync2, phase2} !== {(idx == 3), e_ph}) begin errors++; $display("FAIL p_phase cyc=%0d got=%b/%h exp=%b/%h", k, sync2, phase2, (idx == 3), e_ph); end
      checks++; if (cyc_cnt2 !== e_cnt) begin errors++; $display("FAIL p_cyc_cnt cyc=%0d got=%0d exp=%0d", k, cyc_cnt2, e_cnt); end
      checks++; if ({hold_ack2, resync_err2} !== 2'b00) begin errors++; $display("FAIL p_flags cyc=%0d got=%b exp=00", k, {hold_ack2, resync_err2}); end
    end
  endtask

  initial begin
    poc = 1'b1;
    hold_req = 1'b0;
    slave_mode = 1'b0;
    ext_sync = 1'b0;
    test_pad = 1'b0;
    test_reset();
    test_reset_release();
    test_hold();
    test_slave_resync();
    test_slave_wait();
    test_test_pad();
    test_reset_mid();
    test_param_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/timing_gen.md
# timing_gen

Parametrised two-phase clock and machine-cycle phase generator for the MCS-4 core. It runs from `sysclk` and produces the non-overlapping `clk1`/`clk2` enables, a one-hot N-slot phase ring (A1..X3 for N=8), `sync`, and a machine-cycle counter. It adds a hold/acknowledge handshake, slave-mode re-alignment to an external SYNC, and a configurable-depth TEST synchroniser. It sits ahead of the timing/IO block and replaces the external `clk1_pad`/`clk2_pad` sources.

## Interface
Parameters:
- `CLK_DIV`, default 2: `sysclk` cycles per quarter subcycle (D ≥ 1).
- `NUM_PHASES`, default 8: subcycles per machine cycle (N ≥ 2).
- `SYNC_STAGES`, default 2: flops in the TEST synchroniser (≥ 2).
- `CNT_W`, default 16: width of the machine-cycle counter.

Ports:
- `sysclk`, in, 1: the single clock; all state changes on its rising edge.
- `poc`, in, 1: reset; asynchronous, active-high.
- `hold_req`, in, 1: request to stop at the next machine-cycle boundary.
- `hold_ack`, out, 1: generator is stopped.
- `slave_mode`, in, 1: 1 = re-align the phase ring to `ext_sync`.
- `ext_sync`, in, 1: external SYNC; already synchronous to `sysclk`.
- `test_pad`, in, 1: asynchronous TEST pin.
- `test_n`, out, 1: synchronised, inverted TEST.
- `clk1`, out, 1: phase-1 clock enable.
- `clk2`, out, 1: phase-2 clock enable.
- `phase`, out, N: one-hot subcycle; bit 0 = A1.
- `sync`, out, 1: high during phase N-1.
- `resync_err`, out, 1: one-cycle pulse when slave re-alignment moves the ring.
- `cyc_cnt`, out, CNT_W: completed machine cycles, modulo 2^CNT_W.

## Operation
- **State machine:** IDLE, RUN, HOLD. `poc` forces IDLE asynchronously.
- **IDLE:** at the first edge with `poc` low, go to RUN with q=0.
- **Subcycle counter q:** runs 0..4D-1 in RUN and wraps.
  - `clk1` = RUN & (q < D).
  - `clk2` = RUN & (2D ≤ q < 3D).
  - Both are decoded from registered state only, so they are glitch-free and never high together.
- **Phase advance:** occurs on the edge where q goes 3D-1 → 3D, i.e. at the falling edge of `clk2`.
  - Free mode: the ring rotates one position; N-1 goes to 0.
  - Slave mode, `ext_sync`=1 at the advance edge: the next phase is 0. If the current phase ≠ N-1, `resync_err` pulses for one cycle.
  - Slave mode, `ext_sync`=0 while phase = N-1: the ring stays at N-1 (waits for sync). `cyc_cnt` does not increment.
- **Cycle counter:** `cyc_cnt` increments on every advance into phase 0 from N-1 or via resync, and wraps at 2^CNT_W.
- **Machine-cycle boundary:** q = 4D-1 with phase = 0.
  - If `hold_req`=1 there, go to HOLD, set q=0, `hold_ack`=1, and force `clk1`/`clk2` low.
- **HOLD:** the ring, q and the counter are frozen.
  - When `hold_req`=0 at an edge, go to RUN and drop `hold_ack`; `clk1` rises at that same edge.
  - `hold_req` sampled anywhere other than the boundary has no effect until the boundary.
- **TEST path:** `test_pad` passes through SYNC_STAGES flops; `test_n` is the inverse of the last stage.
- **Reset values** (`poc`=1):
  - `clk1`=`clk2`=0, `hold_ack`=0, `resync_err`=0.
  - `phase` = one-hot bit 0, `sync`=0, `cyc_cnt`=0, q=0.
  - TEST flops = 0, so `test_n`=1.
- **Reset mid-operation:** all outputs return to their reset values immediately (asynchronously). Partial subcycles are discarded.

## Timing
- **Subcycle:** 4D `sysclk` cycles (8 for D=2). Machine cycle: 4D·N cycles (64 for the defaults).
- **After `poc` falls (D=2):**
  - Edge 1: RUN, `clk1`=1 for 2 cycles.
  - Then a 2-cycle gap, `clk2` for 2 cycles, and a 2-cycle gap.
  - The phase changes on the edge that lowers `clk2`.
- **`sync`:** high from the advance edge into N-1 until the advance edge out of it. It has zero latency relative to `phase`.
- **`hold_ack`:** rises on the boundary edge, which is the edge that would have raised `clk1`. It falls one edge after `hold_req` is seen low.
- **`test_n`:** follows `test_pad` after SYNC_STAGES edges.
- **Simultaneous events:** `poc` overrides everything. At the boundary, hold takes priority over the next `clk1`. A resync on the same advance edge is applied before the hold check.

## Test plan
- **Reset release, defaults:** release `poc`, run 64 cycles. Expect `clk1` high on cycles 1-2, 9-10, …; `clk2` high on 5-6, …; never overlapping. Expect `phase` bit0→bit1 at cycle 7, `sync` high on cycles 55-62, and `cyc_cnt`=1 after cycle 63.
- **Hold:** assert `hold_req` at cycle 20 and hold it. Expect `hold_ack`=1 at cycle 65 with clocks low and `cyc_cnt` frozen at 1. Drop `hold_req` after 10 cycles; expect `clk1`=1 and `hold_ack`=0 on the next edge.
- **Slave resync:** `slave_mode`=1, pulse `ext_sync` at the advance edge while phase=3. Expect `phase`=bit0, one `resync_err` pulse, and `cyc_cnt`+1.
- **Slave wait:** `slave_mode`=1 with `ext_sync` held 0. Expect the ring stuck at N-1 with `sync` constantly high and no count. Then `ext_sync`=1 gives phase 0 with no `resync_err`.
- **TEST and reset mid-run:** toggle `test_pad`; `test_n` follows after 2 edges. Assert `poc` at q=4, phase 5; all outputs reset the same cycle, without waiting for an edge.
- **Parameter sweep:** D=1, N=4, CNT_W=2. Expect 4-cycle subcycles and `cyc_cnt` wrapping 3→0 after the 4th machine cycle.
